// File: rtl/fdiv_pkg.sv
// Shared types and constants for the sequential single-precision divider.
package fdiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StDiv,
    StRnd
  } state_e;

  localparam logic [1:0] RM_NEAR = 2'd0;
  localparam logic [1:0] RM_DOWN = 2'd1;
  localparam logic [1:0] RM_UP   = 2'd2;
  localparam logic [1:0] RM_ZERO = 2'd3;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned QBITS   = 26;

endpackage

// File: rtl/fdiv_lzc24.sv
// Combinational leading-zero counter for a 24-bit significand; all-zero input yields 24.
module fdiv_lzc24 (
  input  logic [23:0] val_i,
  output logic [4:0]  cnt_o
);

  always_comb begin
    cnt_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (val_i[i]) cnt_o = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Multi-cycle IEEE single-precision divider (radix-2 restoring), start/busy/done handshake.
// Optional exception flags output enabled by defining FDIV_FLAGS_EN.
module fdiv_seq
  import fdiv_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  rm,
  output logic [31:0] s,
  output logic        busy,
  output logic        done
`ifdef FDIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  state_e             state_q;
  logic [31:0]        a_q, b_q, spec_val_q, s_q;
  logic [1:0]         rm_q;
  logic               sign_q, spec_q, busy_q, done_q;
  logic signed [9:0]  exp_q;
  logic [25:0]        rem_q, quo_q;
  logic [23:0]        mb_q;
  logic [4:0]         cnt_q;

  // Operand classification and normalisation (used in StNorm)
  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic [23:0]        ma, mb, ma_n, mb_n;
  logic [4:0]         lza, lzb;
  logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic signed [9:0]  ea_eff, eb_eff, norm_exp;
  logic [25:0]        norm_rem;
  logic               norm_sign, norm_spec;
  logic [31:0]        norm_spec_val;

  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign fa = a_q[22:0];
  assign fb = b_q[22:0];
  assign ma = {ea != 8'd0, fa};
  assign mb = {eb != 8'd0, fb};

  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign a_zero = (ea == 8'd0) && (fa == 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign b_zero = (eb == 8'd0) && (fb == 23'd0);

  fdiv_lzc24 u_lzc_a (.val_i(ma), .cnt_o(lza));
  fdiv_lzc24 u_lzc_b (.val_i(mb), .cnt_o(lzb));

  always_comb begin
    ma_n     = ma << lza;
    mb_n     = mb << lzb;
    // Subnormals carry an effective exponent of 1 before normalisation
    ea_eff   = $signed({2'b00, (ea == 8'd0) ? 8'd1 : ea}) - $signed({5'd0, lza});
    eb_eff   = $signed({2'b00, (eb == 8'd0) ? 8'd1 : eb}) - $signed({5'd0, lzb});
    norm_exp = ea_eff - eb_eff + $signed(10'(BIAS));
    // Pre-shift a smaller dividend so the first quotient bit is always 1
    if (ma_n < mb_n) begin
      norm_rem = {1'b0, ma_n, 1'b0};
      norm_exp = norm_exp - 10'sd1;
    end else begin
      norm_rem = {2'b00, ma_n};
    end

    norm_sign     = a_q[31] ^ b_q[31];
    norm_spec     = 1'b1;
    norm_spec_val = QNAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      norm_spec_val = QNAN;
    end else if (a_inf || b_zero) begin
      norm_spec_val = {norm_sign, 8'hFF, 23'd0};
    end else if (b_inf || a_zero) begin
      norm_spec_val = {norm_sign, 31'd0};
    end else begin
      norm_spec = 1'b0;
    end
  end

  // One restoring-division step (used in StDiv)
  logic        div_ge;
  logic [25:0] div_diff, div_rem;

  always_comb begin
    div_ge   = rem_q >= {2'b00, mb_q};
    div_diff = div_ge ? (rem_q - {2'b00, mb_q}) : rem_q;
    div_rem  = div_diff << 1;
  end

  // Denormalise, round and pack (used in StRnd)
  logic        tiny, g_bit, r_bit, st_bit, lost, inc, ovf, inexact;
  logic [9:0]  sh;
  logic [4:0]  sh_c;
  logic [52:0] wide;
  logic [25:0] shifted;
  logic [7:0]  e_field;
  logic [30:0] sum;
  logic [31:0] ovf_val, rnd_result;

  always_comb begin
    tiny = exp_q <= 10'sd0;
    sh   = 10'd1 - exp_q;
    // Beyond 27 places every quotient bit lands in sticky
    sh_c = (sh > 10'd27) ? 5'd27 : sh[4:0];
    wide = {quo_q, 27'd0} >> sh_c;
    if (tiny) begin
      shifted = wide[52:27];
      lost    = wide[26:0] != 27'd0;
    end else begin
      shifted = quo_q;
      lost    = 1'b0;
    end
    g_bit   = shifted[1];
    r_bit   = shifted[0];
    st_bit  = (rem_q != 26'd0) || lost;
    inexact = g_bit || r_bit || st_bit;

    unique case (rm_q)
      RM_NEAR: inc = g_bit && (r_bit || st_bit || shifted[2]);
      RM_DOWN: inc = sign_q && inexact;
      RM_UP:   inc = !sign_q && inexact;
      RM_ZERO: inc = 1'b0;
      default: inc = 1'b0;
    endcase

    // Hidden bit adds back the 1 taken off the exponent field; carries ripple naturally
    e_field = tiny ? 8'd0 : (exp_q[7:0] - 8'd1);
    sum     = {e_field, 23'd0} + {7'd0, shifted[25:2]} + {30'd0, inc};
    ovf     = (!tiny && (exp_q >= $signed(10'(EXP_MAX)))) || (sum[30:23] == 8'hFF);

    unique case (rm_q)
      RM_NEAR: ovf_val = {sign_q, 8'hFF, 23'd0};
      RM_DOWN: ovf_val = sign_q ? 32'hFF800000 : 32'h7F7FFFFF;
      RM_UP:   ovf_val = sign_q ? 32'hFF7FFFFF : 32'h7F800000;
      RM_ZERO: ovf_val = {sign_q, 31'h7F7FFFFF};
      default: ovf_val = {sign_q, 8'hFF, 23'd0};
    endcase

    if (spec_q)   rnd_result = spec_val_q;
    else if (ovf) rnd_result = ovf_val;
    else          rnd_result = {sign_q, sum};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= StIdle;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      rm_q       <= 2'd0;
      sign_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      exp_q      <= 10'sd0;
      rem_q      <= 26'd0;
      quo_q      <= 26'd0;
      mb_q       <= 24'd0;
      cnt_q      <= 5'd0;
      s_q        <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            rm_q    <= rm;
            busy_q  <= 1'b1;
            state_q <= StNorm;
          end
        end
        StNorm: begin
          sign_q     <= norm_sign;
          spec_q     <= norm_spec;
          spec_val_q <= norm_spec_val;
          exp_q      <= norm_exp;
          rem_q      <= norm_rem;
          mb_q       <= mb_n;
          quo_q      <= 26'd0;
          cnt_q      <= 5'd0;
          state_q    <= StDiv;
        end
        StDiv: begin
          rem_q <= div_rem;
          quo_q <= {quo_q[24:0], div_ge};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(QBITS - 1)) state_q <= StRnd;
        end
        StRnd: begin
          s_q     <= rnd_result;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s    = s_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef FDIV_FLAGS_EN
  logic [4:0] norm_sflags, spec_flags_q, rnd_flags, flags_q;

  always_comb begin
    norm_sflags = 5'd0;
    norm_sflags[4] = (a_zero && b_zero) || (a_inf && b_inf) ||
                     (a_nan && !a_q[22]) || (b_nan && !b_q[22]);
    norm_sflags[3] = b_zero && !a_zero && !a_inf && !a_nan;
    rnd_flags = spec_q ? spec_flags_q : {2'b00, ovf, tiny && inexact, inexact || ovf};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      spec_flags_q <= 5'd0;
      flags_q      <= 5'd0;
    end else begin
      if (state_q == StNorm) spec_flags_q <= norm_sflags;
      if (state_q == StRnd)  flags_q      <= rnd_flags;
    end
  end

  assign flags = flags_q;
`endif

endmodule
